// File: rtl/imem_access_arbiter.sv
// rtl/imem_access_arbiter.sv - instruction memory port arbiter between core fetch and program loader
module imem_access_arbiter #(
    parameter int MEM_SIZE = 64,
    parameter int ADDR_W   = 32,
    parameter int CNT_W    = $clog2(MEM_SIZE) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              fetch_req_i,
    input  logic [ADDR_W-1:0] fetch_addr_i,
    output logic              fetch_gnt_o,
    output logic [31:0]       fetch_instr_o,
    output logic              fetch_valid_o,
    output logic              core_stall_o,
    input  logic              ld_req_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [31:0]       ld_data_i,
    input  logic              ld_done_i,
    output logic              ld_gnt_o,
    output logic [CNT_W-1:0]  ld_count_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    output logic              err_o
);

    localparam logic [31:0]      NOP_INSTR = 32'h00000013;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MEM_SIZE);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        LOAD   = 2'd2,
        RESUME = 2'd3
    } state_t;

    state_t state;

    // word aligned and inside the array
    function automatic logic addr_legal(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] word_idx;
        word_idx = addr >> 2;
        return (addr[1:0] == 2'b00) && (word_idx < ADDR_W'(MEM_SIZE));
    endfunction

    logic fetch_legal;
    logic ld_legal;

    assign fetch_legal = addr_legal(fetch_addr_i);
    assign ld_legal    = addr_legal(ld_addr_i);

    // port ownership follows the state: loader only in LOAD, fetch only in RUN
    assign fetch_gnt_o  = (state == RUN) && fetch_req_i;
    assign ld_gnt_o     = (state == LOAD) && ld_req_i;
    assign mem_addr_o   = (state == LOAD) ? ld_addr_i : fetch_addr_i;
    assign mem_we_o     = ld_gnt_o && ld_legal;
    assign mem_wdata_o  = ld_data_i;
    assign core_stall_o = (state != RUN);

    // arbitration FSM with the fetch response, load counter and sticky error
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= RUN;
            fetch_instr_o <= NOP_INSTR;
            fetch_valid_o <= 1'b0;
            ld_count_o    <= '0;
            err_o         <= 1'b0;
        end else begin
            fetch_valid_o <= 1'b0;
            case (state)
                RUN: begin
                    // a fetch in the same cycle as a load request still wins that cycle
                    if (fetch_req_i) begin
                        fetch_valid_o <= 1'b1;
                        if (fetch_legal) begin
                            fetch_instr_o <= mem_rdata_i;
                        end else begin
                            fetch_instr_o <= NOP_INSTR;
                            err_o         <= 1'b1;
                        end
                    end
                    if (ld_req_i) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // the in-flight response is visible this cycle; a new session starts clean
                    ld_count_o <= '0;
                    err_o      <= 1'b0;
                    state      <= LOAD;
                end
                LOAD: begin
                    // a write offered with done is still consumed before leaving
                    if (ld_req_i) begin
                        if (ld_legal) begin
                            if (ld_count_o != CNT_MAX) begin
                                ld_count_o <= ld_count_o + 1'b1;
                            end
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                    if (ld_done_i) begin
                        state <= RESUME;
                    end
                end
                RESUME: begin
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_access_arbiter.sv
// tb/tb_imem_access_arbiter.sv - randomized self-checking bench for imem_access_arbiter
module tb_imem_access_arbiter;

    localparam int MEM_SIZE = 64;
    localparam int ADDR_W   = 32;
    localparam int CNT_W    = $clog2(MEM_SIZE) + 1;
    localparam logic [31:0] NOP = 32'h00000013;

    localparam int P_RUN    = 0;
    localparam int P_DRAIN  = 1;
    localparam int P_LOAD   = 2;
    localparam int P_RESUME = 3;

    logic              clk;
    logic              rst;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_gnt;
    logic [31:0]       fetch_instr;
    logic              fetch_valid;
    logic              core_stall;
    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic [31:0]       ld_data;
    logic              ld_done;
    logic              ld_gnt;
    logic [CNT_W-1:0]  ld_count;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              err;

    imem_access_arbiter #(
        .MEM_SIZE(MEM_SIZE),
        .ADDR_W  (ADDR_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .fetch_req_i  (fetch_req),
        .fetch_addr_i (fetch_addr),
        .fetch_gnt_o  (fetch_gnt),
        .fetch_instr_o(fetch_instr),
        .fetch_valid_o(fetch_valid),
        .core_stall_o (core_stall),
        .ld_req_i     (ld_req),
        .ld_addr_i    (ld_addr),
        .ld_data_i    (ld_data),
        .ld_done_i    (ld_done),
        .ld_gnt_o     (ld_gnt),
        .ld_count_o   (ld_count),
        .mem_addr_o   (mem_addr),
        .mem_we_o     (mem_we),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata),
        .err_o        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // instruction memory array the DUT drives
    logic [31:0] mem [MEM_SIZE];
    assign mem_rdata = ((mem_addr >> 2) < MEM_SIZE) ? mem[mem_addr[7:2]] : 32'hdeadbeef;
    always @(posedge clk) begin
        if (mem_we && ((mem_addr >> 2) < MEM_SIZE)) mem[mem_addr[7:2]] <= mem_wdata;
    end

    // reference model: expected memory contents and expected visible outputs
    logic [31:0] shadow [MEM_SIZE];
    int          phase;
    logic        exp_valid;
    logic [31:0] exp_instr;
    int          exp_count;
    logic        exp_err;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ((a >> 2) < MEM_SIZE);
    endfunction

    // mostly legal word addresses, sometimes misaligned or past the end
    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 99);
        if (r < 85) return 32'($urandom_range(0, MEM_SIZE - 1)) << 2;
        if (r < 93) return (32'($urandom_range(0, MEM_SIZE - 1)) << 2) | 32'($urandom_range(1, 3));
        return 32'($urandom_range(MEM_SIZE, 4 * MEM_SIZE)) << 2;
    endfunction

    task automatic model_reset();
        phase     = P_RUN;
        exp_valid = 1'b0;
        exp_instr = NOP;
        exp_count = 0;
        exp_err   = 1'b0;
    endtask

    task automatic check_regs(input string pfx);
        chk({pfx, "_valid"}, 32'(fetch_valid), 32'(exp_valid));
        chk({pfx, "_instr"}, fetch_instr, exp_instr);
        chk({pfx, "_stall"}, 32'(core_stall), 32'(phase != P_RUN));
        chk({pfx, "_count"}, 32'(ld_count), 32'(exp_count));
        chk({pfx, "_err"}, 32'(err), 32'(exp_err));
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        fetch_req = 1'b0;
        ld_req    = 1'b0;
        ld_done   = 1'b0;
        #1;
        model_reset();
        check_regs("rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // one clock: check registered outputs, drive, check combinational outputs, advance model
    task automatic step(input logic freq, input logic [31:0] faddr, input logic lreq,
                        input logic [31:0] laddr, input logic [31:0] ldat, input logic ldone);
        logic exp_fg;
        logic exp_lg;
        @(posedge clk);
        #1;
        check_regs("reg");
        fetch_req  = freq;
        fetch_addr = faddr;
        ld_req     = lreq;
        ld_addr    = laddr;
        ld_data    = ldat;
        ld_done    = ldone;
        #1;
        exp_fg = (phase == P_RUN) && freq;
        exp_lg = (phase == P_LOAD) && lreq;
        chk("fetch_gnt", 32'(fetch_gnt), 32'(exp_fg));
        chk("ld_gnt", 32'(ld_gnt), 32'(exp_lg));
        chk("mem_we", 32'(mem_we), 32'(exp_lg && legal(laddr)));
        chk("mem_wdata", mem_wdata, ldat);
        if (exp_fg) chk("mem_addr_f", mem_addr, faddr);
        if (exp_lg) chk("mem_addr_l", mem_addr, laddr);
        exp_valid = 1'b0;
        case (phase)
            P_RUN: begin
                if (freq) begin
                    exp_valid = 1'b1;
                    if (legal(faddr)) exp_instr = shadow[faddr >> 2];
                    else begin
                        exp_instr = NOP;
                        exp_err   = 1'b1;
                    end
                end
                if (lreq) phase = P_DRAIN;
            end
            P_DRAIN: begin
                exp_count = 0;
                exp_err   = 1'b0;
                phase     = P_LOAD;
            end
            P_LOAD: begin
                if (lreq) begin
                    if (legal(laddr)) begin
                        shadow[laddr >> 2] = ldat;
                        if (exp_count < MEM_SIZE) exp_count++;
                    end else exp_err = 1'b1;
                end
                if (ldone) phase = P_RESUME;
            end
            default: phase = P_RUN;
        endcase
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 32'h0, $urandom, 1'b0);
    endtask

    task automatic fetch(input logic [31:0] a);
        step(1'b1, a, 1'b0, 32'h0, $urandom, 1'b0);
    endtask

    task automatic lwrite(input logic [31:0] a, input logic [31:0] d);
        step(1'b0, 32'h0, 1'b1, a, d, 1'b0);
    endtask

    // request the port (with a concurrent fetch) and pass through DRAIN
    task automatic enter_load(input logic [31:0] fa);
        step(1'b1, fa, 1'b1, 32'h0, $urandom, 1'b0);
        step(1'b1, fa, 1'b1, 32'h0, $urandom, 1'b0);
    endtask

    task automatic finish_load();
        step(1'b0, 32'h0, 1'b0, 32'h0, $urandom, 1'b1);
        step(1'b1, 32'h0, 1'b1, 32'h0, $urandom, 1'b0);
    endtask

    initial begin
        fetch_req  = 1'b0;
        fetch_addr = '0;
        ld_req     = 1'b0;
        ld_addr    = '0;
        ld_data    = '0;
        ld_done    = 1'b0;
        for (int i = 0; i < MEM_SIZE; i++) begin
            mem[i]    = $urandom;
            shadow[i] = mem[i];
        end
        mem[0] = 32'h00518193; shadow[0] = 32'h00518193;
        mem[1] = 32'h00a20213; shadow[1] = 32'h00a20213;
        mem[2] = 32'h003202b3; shadow[2] = 32'h003202b3;
        do_reset();

        // back-to-back fetches
        fetch(32'h0);
        fetch(32'h4);
        fetch(32'h8);
        idle();

        // load four copies of one word, then read one back
        enter_load(32'h10);
        for (int i = 0; i < 4; i++) lwrite(32'(i * 4), 32'h00ae0e13);
        finish_load();
        idle();
        fetch(32'h4);
        idle();

        // illegal loader addresses, then a clean session clears err
        enter_load(32'h0);
        lwrite(32'h102, $urandom);
        lwrite(32'h100, $urandom);
        finish_load();
        idle();
        enter_load(32'h8);
        idle();
        finish_load();
        idle();

        // out-of-range fetch returns NOP and err sticks
        fetch(32'h100);
        fetch(32'h0);
        idle();
        idle();

        // randomized traffic across all phases
        for (int n = 0; n < 600; n++) begin
            logic fr;
            logic lr;
            logic dn;
            fr = ($urandom_range(0, 99) < 70);
            lr = (phase == P_LOAD) ? ($urandom_range(0, 99) < 70) : ($urandom_range(0, 99) < 8);
            dn = (phase == P_LOAD) && ($urandom_range(0, 99) < 6);
            step(fr, rand_addr(), lr, rand_addr(), $urandom, dn);
        end
        while (phase != P_RUN) step(1'b0, 32'h0, 1'b0, 32'h0, $urandom, 1'b1);
        for (int i = 0; i < MEM_SIZE; i++) fetch(32'(i * 4));
        idle();

        // counter saturates at MEM_SIZE
        enter_load(32'h0);
        for (int i = 0; i < MEM_SIZE + 6; i++)
            lwrite(32'($urandom_range(0, MEM_SIZE - 1)) << 2, $urandom);
        finish_load();
        idle();

        // reset in the middle of a session keeps written words
        enter_load(32'h0);
        lwrite(32'h20, $urandom);
        lwrite(32'h24, $urandom);
        idle();
        do_reset();
        fetch(32'h20);
        fetch(32'h24);
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
